dmem_bus_stall_unit: RTL
========================

Name: dmem_bus_stall_unit

Overview:
- Data-memory bus front end for the MEM stage of the rv32i pipeline.
- Converts the MEM-stage load/store request into a single Wishbone B4 classic transaction.
- Drives `stall_pipl` into the pipeline controller while the transaction is outstanding.
- Returns the registered read data to the MEM/WB boundary.
- Sits directly upstream of the pipeline controller; it is the sole source of `stall_pipl`.

Parameters:
- ADDR_W, 32, address width of mem_addr and wb_adr_o
- DATA_W, 32, data width; must equal 32
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- mem_read  in  1  MEM stage executes a load
- mem_write  in  1  MEM stage executes a store
- mem_addr  in  ADDR_W  byte address from EXE/MEM
- mem_wdata  in  DATA_W  store data, already lane-aligned
- mem_wsel  in  4  byte-lane select
- mem_rdata  out  DATA_W  load data, valid in DONE
- stall_pipl  out  1  stall request to the pipeline controller
- bus_err  out  1  one-cycle pulse in DONE if the transaction ended in error/timeout
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_W  address
- wb_dat_o  out  DATA_W  write data
- wb_sel_o  out  4  byte select
- wb_dat_i  in  DATA_W  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error termination

Behaviour:
- `req = mem_read | mem_write`. If both are high, the access is treated as a write.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req, go to BUSY. Register adr/dat/sel/we from the mem_* inputs.
  - BUSY: wb_cyc_o = wb_stb_o = 1. On wb_ack_i or wb_err_i, go to DONE. Capture wb_dat_i into the rdata register on ack for reads. On err, capture zero.
  - DONE: cyc/stb = 0. Go to IDLE unconditionally.
- `stall_pipl = req & (state != DONE)`. This is combinational from req and registered state.
  - Stall is therefore high in IDLE-with-req and throughout BUSY.
  - Stall drops for exactly the DONE cycle, in which all pipeline registers advance.
- Minimum latency:
  - Zero-wait slave (ack in the first BUSY cycle): 2 stall cycles, data in cycle 3.
  - Each extra wait state adds one stall cycle.
- The request is sampled only in IDLE. Changes on mem_* during BUSY/DONE are ignored. Because the pipeline is frozen, they are expected stable anyway.
- No request is reissued for the same instruction. DONE guarantees a one-cycle gap: a back-to-back access from the next instruction starts in the IDLE cycle after DONE.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o are held for the whole of BUSY.
- wb_we_o = 0 and wb_sel_o = 0 outside BUSY.
- mem_rdata holds its last captured value until the next read completes.
- bus_err is high only in DONE when the termination was wb_err_i (or a timeout).
- Simultaneous wb_ack_i and wb_err_i: err wins, and data is zeroed.
- Reset:
  - Asynchronous reset forces IDLE immediately.
  - All outputs and registers go to 0: cyc, stb, we, adr, dat, sel, mem_rdata, bus_err.
  - stall_pipl becomes 0 except when req is high.
  - A reset mid-BUSY abandons the transaction; cyc drops without ack.
- The ack/err inputs are ignored outside BUSY.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES with no ack/err, the FSM goes to DONE with error semantics: bus_err=1, rdata=0, cyc/stb dropped.
  - A late ack after abort is ignored.
- Not defined:
  - No counter is present.
  - BUSY waits indefinitely for ack/err.

Test Plan:
- Load, zero-wait slave:
  - Stimulus: mem_read=1, addr 0x100; slave acks in the first BUSY cycle with 0xDEADBEEF.
  - Required response: stall_pipl=1 for 2 cycles, then 0 for one cycle; mem_rdata=0xDEADBEEF in DONE; cyc high exactly 1 cycle.
- Store, 3 wait states:
  - Stimulus: mem_write=1, addr 0x200, wdata 0x12345678, sel 4'b0011.
  - Required response: we=1, sel=0011, data stable for 4 BUSY cycles; stall high for 5 cycles; bus_err=0.
- Back-to-back accesses:
  - Stimulus: load followed immediately by a store.
  - Required response: DONE of the load, then IDLE with stall=1, then the store's BUSY; exactly two cyc pulses separated by at least 2 low cycles.
- Error termination:
  - Stimulus: wb_err_i (with ack simultaneously) on a load.
  - Required response: mem_rdata=0 and bus_err=1 for one cycle, in DONE.
- Reset mid-BUSY:
  - Stimulus: reset_n low two cycles into a wait-state load.
  - Required response: cyc/stb fall asynchronously; after release with req=0, stall_pipl=0 and state is IDLE.
- Timeout (with DMEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: slave never acks.
  - Required response: DONE after 8 BUSY cycles with bus_err=1; a late ack in the following cycle has no effect.

Source files
------------

// File: rtl/dmem_bus_stall_unit.sv
`default_nettype none
// dmem_bus_stall_unit: MEM-stage load/store to single Wishbone B4 classic cycle, with pipeline stall.
// Rev 1.0. Optional BUSY timeout abort: define DMEM_BUS_TIMEOUT_EN.
module dmem_bus_stall_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_wsel,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pipl,
  output logic              bus_err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_cyc;
  logic                r_we;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat;
  logic [3:0]          r_sel;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_bus_err;

  logic w_req;
  logic w_busy;
  logic w_ack;
  logic w_err;
  logic w_timeout;

  assign w_req  = mem_read | mem_write;
  assign w_busy = (r_state == S_BUSY);
  assign w_ack  = w_busy & wb_ack_i;
  assign w_err  = (w_busy & wb_err_i) | w_timeout;

`ifdef DMEM_BUS_TIMEOUT_EN
  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TMO_W-1:0] r_tmo;

  // Held at zero outside BUSY, so it is always clear on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (!w_busy) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_timeout = w_busy & (r_tmo == c_TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= 4'b0000;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bus_err <= 1'b0;
          if (w_req) begin
            r_state <= S_BUSY;
            r_cyc   <= 1'b1;
            r_we    <= mem_write;
            r_adr   <= mem_addr;
            r_dat   <= mem_wdata;
            r_sel   <= mem_wsel;
          end
        end
        S_BUSY: begin
          // Error (or timeout) takes priority over a coincident ack.
          if (w_err) begin
            r_state   <= S_DONE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'b0000;
            r_bus_err <= 1'b1;
            if (!r_we) begin
              r_rdata <= '0;
            end
          end else if (w_ack) begin
            r_state <= S_DONE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'b0000;
            if (!r_we) begin
              r_rdata <= wb_dat_i;
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_bus_err <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_sel   <= 4'b0000;
        end
      endcase
    end
  end

  assign stall_pipl = w_req & (r_state != S_DONE);
  assign mem_rdata  = r_rdata;
  assign bus_err    = r_bus_err;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;
  assign wb_we_o    = r_we;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = r_sel;

endmodule
`default_nettype wire
